bcd_display_conv: RTL and testbench
===================================

// Module: bcd_display_conv
// PURPOSE
//   Sequential binary-to-BCD converter (shift-add-3, one bit per clock) for the
//   calculator operand/result register. Takes the 32-bit unsigned accumulator value
//   built from keypad digits and produces packed BCD digits plus a leading-zero
//   blank mask for the 7-segment display driver.
// PARAMETERS
//   WIDTH   32  width of binary input, unsigned
//   DIGITS  10  BCD digits produced; must satisfy 10^DIGITS > 2^WIDTH-1 (10 for 32)
// PORTS
//   clk      in   1            system clock, rising edge
//   rst_n    in   1            asynchronous reset, active low
//   start    in   1            request conversion of bin_in; sampled only in IDLE
//   bin_in   in   WIDTH        unsigned binary value, captured on accepted start
//   busy     out  1            conversion in progress (SHIFT state)
//   done     out  1            one-cycle pulse: bcd_out/blank hold the new result
//   bcd_out  out  4*DIGITS     packed BCD, digit 0 (units) in [3:0]
//   blank    out  DIGITS       1 = leading zero to suppress; bit 0 always 0
// BEHAVIOUR
//   Reset (async assert, sync-released by system): state=IDLE, busy=0, done=0,
//     bcd_out=0, blank={ {DIGITS-1}1s, 0 }, bit counter=0, scratch regs=0.
//   FSM: IDLE -> SHIFT on start; SHIFT -> IDLE after WIDTH shift cycles.
//   IDLE: done is 0 except in the cycle immediately following SHIFT exit.
//     start=1 at edge E0: capture bin_in into shift reg, clear BCD scratch,
//     counter=0, go SHIFT. busy=1 from E0 onward.
//   SHIFT: each edge: per digit, if digit>=5 add 3 (4-bit, no carry out), then
//     shift {scratch,shiftreg} left 1; MSB of shiftreg enters scratch bit 0;
//     counter++. Edges E1..E(WIDTH) perform the WIDTH shifts.
//   At edge E(WIDTH): bcd_out <= final scratch value, blank <= mask from it,
//     done <= 1, busy <= 0, state <= IDLE. Latency start->done = WIDTH edges.
//   done is a single-cycle pulse; it clears on the next edge regardless of start.
//   start in the done cycle is accepted (back-to-back period WIDTH+1 cycles).
//   start while busy: ignored, no queuing; bin_in changes while busy ignored.
//   bcd_out/blank hold the previous result throughout a conversion; they only
//     change on the done edge.
//   Blank mask: blank[i]=1 iff digits i..DIGITS-1 all zero, for i>=1; blank[0]=0.
//     Computed combinationally from the scratch value, registered with bcd_out.
//   Any carry beyond digit DIGITS-1 is discarded (illegal parameter choice only).
//   rst_n low mid-conversion: immediate return to reset values; aborted result
//     never appears; no done pulse.
// TESTING
//   T1 reset then start with bin_in=0 -> done exactly 32 edges later, bcd_out=0,
//      blank=10'b11_1111_1110, busy high for 32 cycles.
//   T2 bin_in=1234 -> bcd_out=40'h00_0000_1234, blank=10'b11_1111_0000.
//   T3 bin_in=32'hFFFF_FFFF -> bcd_out=40'h42_9496_7295, blank=0.
//   T4 start=1234, pulse start again with bin_in=99 at cycle 10 -> ignored,
//      result still 1234; then start with 99 in done cycle -> 40'h99 after 32 more.
//   T5 start bin_in=5678, drop rst_n at cycle 15 -> outputs at reset values, no
//      done; after release start 5678 -> 40'h5678, blank=10'b11_1111_0000.
//   T6 random 1000 values vs. reference model, checking done latency and that
//      bcd_out/blank are stable between done pulses.

Source files
------------

// File: rtl/bcd_display_conv.sv
// ---------------------------------------------------------------------------
// bcd_display_conv
//   Sequential binary-to-BCD converter using the shift-add-3 (double dabble)
//   method, one input bit per clock. It converts the calculator's unsigned
//   accumulator value into packed BCD digits and a leading-zero blank mask
//   for the 7-segment display driver.
//
// Ports
//   clk      in   1          system clock, rising edge
//   rst_n    in   1          asynchronous reset, active low
//   start    in   1          request a conversion; only honoured while idle
//   bin_in   in   WIDTH      unsigned binary value, captured on accepted start
//   busy     out  1          high while a conversion is in progress
//   done     out  1          one-cycle pulse when bcd_out/blank hold a new result
//   bcd_out  out  4*DIGITS   packed BCD, digit 0 (units) in [3:0]
//   blank    out  DIGITS     1 = leading zero to suppress; bit 0 is always 0
// ---------------------------------------------------------------------------
module bcd_display_conv #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     blank
);

    localparam int                CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]     LAST      = CW'(WIDTH - 1);
    localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t              state_q;
    logic [WIDTH-1:0]    shift_q;
    logic [4*DIGITS-1:0] scratch_q;
    logic [CW-1:0]       count_q;
    logic                busy_q;
    logic                done_q;
    logic [4*DIGITS-1:0] bcd_q;
    logic [DIGITS-1:0]   blank_q;

    logic [4*DIGITS-1:0] adjusted;
    logic [4*DIGITS-1:0] scratch_d;
    logic [DIGITS-1:0]   blank_d;
    logic                allZero;

    // Add-3 correction: any digit of 5 or more would overflow past 9 when
    // doubled by the coming shift, so bias it by 3 to carry into the next digit.
    always_comb begin
        adjusted = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Shift the corrected digits left, pulling in the next binary MSB.
    // Anything shifted out of the top digit is dropped.
    assign scratch_d = {adjusted[4*DIGITS-2:0], shift_q[WIDTH-1]};

    // Leading-zero mask from the value about to be registered: a digit is
    // blanked when it and every digit above it are zero. Units never blank.
    always_comb begin
        blank_d = '0;
        allZero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            allZero    = allZero & (scratch_d[4*i +: 4] == 4'd0);
            blank_d[i] = allZero;
        end
    end

    // Control FSM and datapath. Results only update on the final shift edge,
    // so the display keeps showing the previous value during a conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            blank_q   <= BLANK_RST;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shift_q   <= bin_in;
                        scratch_q <= '0;
                        count_q   <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch_q <= scratch_d;
                    shift_q   <= {shift_q[WIDTH-2:0], 1'b0};
                    count_q   <= count_q + CW'(1);
                    if (count_q == LAST) begin
                        bcd_q   <= scratch_d;
                        blank_q <= blank_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;
    assign blank   = blank_q;

endmodule

// File: tb/tb_bcd_display_conv.sv
// ---------------------------------------------------------------------------
// tb_bcd_display_conv
//   Directed testbench for bcd_display_conv (WIDTH=32, DIGITS=10). Inputs
//   are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_bcd_display_conv;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] bin_in;
    logic        busy;
    logic        done;
    logic [39:0] bcd_out;
    logic [9:0]  blank;

    int vectors;
    int misses;

    bcd_display_conv #(
        .WIDTH  (32),
        .DIGITS (10)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .blank   (blank)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            misses++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Present start with a value for one rising edge (E0), leaving the bench
    // at the falling edge right after E0.
    task automatic applyStimulus(input logic [31:0] value);
        start  = 1'b1;
        bin_in = value;
        @(negedge clk);
        start  = 1'b0;
        bin_in = 32'hDEAD_BEEF;
    endtask

    // Wait (bounded) for done, counting edges and watching busy and the
    // held result while the conversion runs.
    task automatic waitDone(output int cycles, output int busyLow, output bit held);
        logic [39:0] bcd0;
        logic [9:0]  blank0;
        bcd0    = bcd_out;
        blank0  = blank;
        cycles  = 0;
        busyLow = 0;
        held    = 1'b1;
        while (done !== 1'b1 && cycles < 40) begin
            if (busy !== 1'b1) busyLow++;
            if (bcd_out !== bcd0 || blank !== blank0) held = 1'b0;
            @(negedge clk);
            cycles++;
        end
    endtask

    // Full conversion with latency, busy, hold and result checks.
    task automatic runConversion(input string tag, input logic [31:0] value,
                                 input logic [39:0] expBcd, input logic [9:0] expBlank);
        int cycles;
        int busyLow;
        bit held;
        applyStimulus(value);
        waitDone(cycles, busyLow, held);
        checkOutput({tag, " latency"}, 64'(cycles), 64'd32);
        checkOutput({tag, " busy during"}, 64'(busyLow), 64'd0);
        checkOutput({tag, " result held"}, 64'(held), 64'd1);
        checkOutput({tag, " busy at done"}, 64'(busy), 64'd0);
        checkOutput({tag, " bcd"}, 64'(bcd_out), 64'(expBcd));
        checkOutput({tag, " blank"}, 64'(blank), 64'(expBlank));
        @(negedge clk);
        checkOutput({tag, " done pulse width"}, 64'(done), 64'd0);
    endtask

    // Reference: decimal digits by repeated division.
    function automatic logic [39:0] refBcd(input logic [31:0] value);
        logic [39:0] r;
        logic [31:0] v;
        r = '0;
        v = value;
        for (int i = 0; i < 10; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Reference: digit i is a leading zero exactly when value < 10^i.
    function automatic logic [9:0] refBlank(input logic [31:0] value);
        logic [9:0]  m;
        logic [63:0] p;
        m = '0;
        p = 64'd1;
        for (int i = 1; i < 10; i++) begin
            p = p * 10;
            m[i] = (64'(value) < p);
        end
        return m;
    endfunction

    // Directed sequence.
    initial begin
        int          cycles;
        int          busyLow;
        int          donesSeen;
        bit          held;
        logic [31:0] rv;

        vectors = 0;
        misses  = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        bin_in  = '0;

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset bcd", 64'(bcd_out), 64'd0);
        checkOutput("reset blank", 64'(blank), 64'(10'b11_1111_1110));
        rst_n = 1'b1;
        @(negedge clk);

        // T1..T3 plus digit boundaries
        runConversion("zero", 32'd0, 40'h00_0000_0000, 10'b11_1111_1110);
        runConversion("1234", 32'd1234, 40'h00_0000_1234, 10'b11_1111_0000);
        runConversion("max", 32'hFFFF_FFFF, 40'h42_9496_7295, 10'b00_0000_0000);
        runConversion("nine", 32'd9, 40'h00_0000_0009, 10'b11_1111_1110);
        runConversion("ten", 32'd10, 40'h00_0000_0010, 10'b11_1111_1100);
        runConversion("99999", 32'd99999, 40'h00_0009_9999, 10'b11_1110_0000);
        runConversion("1e9", 32'd1_000_000_000, 40'h10_0000_0000, 10'b00_0000_0000);
        runConversion("3e9", 32'd3_000_000_000, 40'h30_0000_0000, 10'b00_0000_0000);

        // A few random values against the division model
        for (int n = 0; n < 8; n++) begin
            rv = $urandom;
            runConversion("random", rv, refBcd(rv), refBlank(rv));
        end

        // T4: start while busy is ignored, start in the done cycle is taken
        applyStimulus(32'd1234);
        repeat (9) @(negedge clk);
        applyStimulus(32'd99);
        waitDone(cycles, busyLow, held);
        checkOutput("ignore latency", 64'(cycles), 64'd22);
        checkOutput("ignore busy", 64'(busyLow), 64'd0);
        checkOutput("ignore bcd", 64'(bcd_out), 64'h00_0000_1234);
        checkOutput("ignore blank", 64'(blank), 64'(10'b11_1111_0000));
        applyStimulus(32'd99);
        checkOutput("b2b done cleared", 64'(done), 64'd0);
        checkOutput("b2b busy", 64'(busy), 64'd1);
        waitDone(cycles, busyLow, held);
        checkOutput("b2b latency", 64'(cycles), 64'd32);
        checkOutput("b2b held", 64'(held), 64'd1);
        checkOutput("b2b bcd", 64'(bcd_out), 64'h00_0000_0099);
        checkOutput("b2b blank", 64'(blank), 64'(10'b11_1111_1100));
        @(negedge clk);

        // T5: reset mid-conversion aborts without a done pulse
        applyStimulus(32'd5678);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort busy", 64'(busy), 64'd0);
        checkOutput("abort done", 64'(done), 64'd0);
        checkOutput("abort bcd", 64'(bcd_out), 64'd0);
        checkOutput("abort blank", 64'(blank), 64'(10'b11_1111_1110));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        donesSeen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) donesSeen++;
        end
        checkOutput("abort no done", 64'(donesSeen), 64'd0);
        runConversion("after abort", 32'd5678, 40'h00_0000_5678, 10'b11_1111_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
